// File: rtl/led_pkg.sv
// Shared types and constants for the LED counter divider programming controller.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        WRITE   = 2'd2,
        CONFIRM = 2'd3
    } state_e;

    localparam logic [1:0] STAT_OK      = 2'b00;
    localparam logic [1:0] STAT_TIMEOUT = 2'b01;
    localparam logic [1:0] STAT_ILLEGAL = 2'b10;

    localparam int DIV_W_DEF = 12;

endpackage

// File: rtl/led_edge_det.sv
// Any-edge detector on the counter's LED toggle: keeps a registered copy and
// flags every cycle where the live input differs from it.
module led_edge_det (
    input  logic clk100,
    input  logic rst,
    input  logic led_int_i,
    output logic edge_o
);

    logic led_q;

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            led_q <= 1'b0;
        end else begin
            led_q <= led_int_i;
        end
    end

    assign edge_o = led_int_i ^ led_q;

endmodule

// File: rtl/led_div_ctrl.sv
// Divider programming controller: accepts a request, drives setup-then-strobe
// onto the counter's divider port, then confirms the update by counting LED edges.
module led_div_ctrl
    import led_pkg::*;
#(
    parameter int               DIV_W         = DIV_W_DEF,
    parameter logic [DIV_W-1:0] DIV_RST       = DIV_W'(1),
    parameter int               CONFIRM_EDGES = 2,
    parameter int               TIMEOUT_CYC   = 100_000_000
) (
    input  logic             clk100,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [DIV_W-1:0] req_div_i,
    output logic [DIV_W-1:0] div_o,
    output logic             wren_o,
    input  logic             led_int_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [1:0]       stat_o
);

    // A one-cycle timeout still needs a 1-bit counter to hold its terminal value.
    localparam int              TMO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]       CONF_N  = 4'(CONFIRM_EDGES);

    state_e             state_q;
    logic [DIV_W-1:0]   div_q;
    logic               wren_q;
    logic               done_q;
    logic [1:0]         stat_q;
    logic [3:0]         edge_cnt_q;
    logic [3:0]         edge_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q;
    logic [TMO_W-1:0]   tmo_cnt_d;
    logic               led_edge;

    led_edge_det u_edge_det (
        .clk100    (clk100),
        .rst       (rst),
        .led_int_i (led_int_i),
        .edge_o    (led_edge)
    );

    assign edge_cnt_d = led_edge ? edge_cnt_q + 4'd1 : edge_cnt_q;
    assign tmo_cnt_d  = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= DIV_RST;
            wren_q     <= 1'b0;
            done_q     <= 1'b0;
            stat_q     <= STAT_OK;
            edge_cnt_q <= 4'd0;
            tmo_cnt_q  <= '0;
        end else begin
            wren_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        if (req_div_i == '0) begin
                            done_q <= 1'b1;
                            stat_q <= STAT_ILLEGAL;
                        end else begin
                            div_q   <= req_div_i;
                            state_q <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    wren_q  <= 1'b1;
                    state_q <= WRITE;
                end
                WRITE: begin
                    edge_cnt_q <= 4'd0;
                    tmo_cnt_q  <= '0;
                    state_q    <= CONFIRM;
                end
                CONFIRM: begin
                    edge_cnt_q <= edge_cnt_d;
                    tmo_cnt_q  <= tmo_cnt_d;
                    // Success is tested first so a final edge on the last timeout cycle still counts.
                    if (edge_cnt_d == CONF_N) begin
                        done_q  <= 1'b1;
                        stat_q  <= STAT_OK;
                        state_q <= IDLE;
                    end else if (tmo_cnt_q == TMO_MAX) begin
                        done_q  <= 1'b1;
                        stat_q  <= STAT_TIMEOUT;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign div_o       = div_q;
    assign wren_o      = wren_q;
    assign done_o      = done_q;
    assign stat_o      = stat_q;

endmodule

// File: tb/tb_led_div_ctrl.sv
// Directed self-checking bench for led_div_ctrl with TIMEOUT_CYC=64, CONFIRM_EDGES=2.
module tb_led_div_ctrl;

    localparam int DIV_W = 12;

    logic             clk100;
    logic             rst;
    logic             reqValid;
    logic             reqReady;
    logic [DIV_W-1:0] reqDiv;
    logic [DIV_W-1:0] divOut;
    logic             wren;
    logic             ledInt;
    logic             busy;
    logic             done;
    logic [1:0]       stat;

    int checks;
    int failures;
    int firstDone;
    int doneCnt;
    int firstWren;
    int wrenCnt;
    int busyCnt;
    int wrenTotal;

    led_div_ctrl #(
        .DIV_W         (DIV_W),
        .DIV_RST       (12'd1),
        .CONFIRM_EDGES (2),
        .TIMEOUT_CYC   (64)
    ) dut (
        .clk100      (clk100),
        .rst         (rst),
        .req_valid_i (reqValid),
        .req_ready_o (reqReady),
        .req_div_i   (reqDiv),
        .div_o       (divOut),
        .wren_o      (wren),
        .led_int_i   (ledInt),
        .busy_o      (busy),
        .done_o      (done),
        .stat_o      (stat)
    );

    initial clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Called in cycle 0 of a transaction; returns positioned in cycle 1.
    task automatic applyStimulus(input logic [DIV_W-1:0] value);
        reqValid = 1'b1;
        reqDiv   = value;
        tick();
        reqValid = 1'b0;
        reqDiv   = 12'hFFF;
    endtask

    // Steps cycles fromCyc..toCyc, toggling ledInt at t1/t2/t3, and records output activity.
    task automatic runCycles(input int fromCyc, input int toCyc, input int t1, input int t2, input int t3);
        firstDone = -1;
        doneCnt   = 0;
        firstWren = -1;
        wrenCnt   = 0;
        busyCnt   = 0;
        for (int c = fromCyc; c <= toCyc; c++) begin
            if (c == t1 || c == t2 || c == t3) ledInt = ~ledInt;
            if (done) begin
                doneCnt++;
                if (firstDone < 0) firstDone = c;
            end
            if (wren) begin
                wrenCnt++;
                if (firstWren < 0) firstWren = c;
            end
            if (busy) busyCnt++;
            tick();
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        reqValid  = 1'b0;
        reqDiv    = '0;
        ledInt    = 1'b0;
        wrenTotal = 0;

        tick();
        tick();
        checkOutput("rst_div", 32'(divOut), 32'h001);
        checkOutput("rst_wren", 32'(wren), 32'h0);
        checkOutput("rst_ready", 32'(reqReady), 32'h1);
        checkOutput("rst_stat", 32'(stat), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        tick();

        $display("[TB] idle after reset");
        runCycles(0, 99, -1, -1, -1);
        checkOutput("idle_done", 32'(doneCnt), 32'd0);
        checkOutput("idle_wren", 32'(wrenCnt), 32'd0);
        checkOutput("idle_div", 32'(divOut), 32'h001);

        $display("[TB] normal write");
        applyStimulus(12'h0A5);
        checkOutput("norm_div_c1", 32'(divOut), 32'h0A5);
        checkOutput("norm_busy_c1", 32'(busy), 32'h1);
        runCycles(1, 30, 10, 20, -1);
        checkOutput("norm_wren_cyc", 32'(firstWren), 32'd2);
        checkOutput("norm_wren_cnt", 32'(wrenCnt), 32'd1);
        checkOutput("norm_done_cyc", 32'(firstDone), 32'd21);
        checkOutput("norm_done_cnt", 32'(doneCnt), 32'd1);
        checkOutput("norm_busy_cnt", 32'(busyCnt), 32'd20);
        checkOutput("norm_stat", 32'(stat), 32'h0);

        $display("[TB] timeout");
        applyStimulus(12'h010);
        runCycles(1, 80, -1, -1, -1);
        checkOutput("tmo_done_cyc", 32'(firstDone), 32'd67);
        checkOutput("tmo_stat", 32'(stat), 32'h1);
        checkOutput("tmo_div", 32'(divOut), 32'h010);

        $display("[TB] illegal request");
        applyStimulus(12'h000);
        runCycles(1, 10, -1, -1, -1);
        checkOutput("ill_done_cyc", 32'(firstDone), 32'd1);
        checkOutput("ill_done_cnt", 32'(doneCnt), 32'd1);
        checkOutput("ill_wren", 32'(wrenCnt), 32'd0);
        checkOutput("ill_busy", 32'(busyCnt), 32'd0);
        checkOutput("ill_stat", 32'(stat), 32'h2);
        checkOutput("ill_div", 32'(divOut), 32'h010);

        $display("[TB] edges in setup and write ignored");
        applyStimulus(12'h055);
        runCycles(1, 80, 1, 2, 10);
        checkOutput("filt_done_cyc", 32'(firstDone), 32'd67);
        checkOutput("filt_stat", 32'(stat), 32'h1);

        $display("[TB] final edge on last timeout cycle");
        applyStimulus(12'h066);
        runCycles(1, 80, 10, 66, -1);
        checkOutput("tie_done_cyc", 32'(firstDone), 32'd67);
        checkOutput("tie_stat", 32'(stat), 32'h0);

        $display("[TB] reset during confirm");
        applyStimulus(12'h0AA);
        runCycles(1, 9, -1, -1, -1);
        rst = 1'b1;
        #1;
        checkOutput("midrst_div", 32'(divOut), 32'h001);
        checkOutput("midrst_busy", 32'(busy), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        runCycles(0, 19, -1, -1, -1);
        checkOutput("midrst_done", 32'(doneCnt), 32'd0);
        checkOutput("midrst_wren", 32'(wrenCnt), 32'd0);

        $display("[TB] back-to-back requests");
        applyStimulus(12'h003);
        runCycles(1, 6, 5, 6, -1);
        wrenTotal = wrenCnt;
        checkOutput("b2b_done1", 32'(done), 32'h1);
        checkOutput("b2b_ready1", 32'(reqReady), 32'h1);
        applyStimulus(12'h004);
        checkOutput("b2b_div2", 32'(divOut), 32'h004);
        runCycles(1, 10, 5, 6, -1);
        wrenTotal += wrenCnt;
        checkOutput("b2b_wren_total", 32'(wrenTotal), 32'd2);
        checkOutput("b2b_done2_cyc", 32'(firstDone), 32'd7);
        checkOutput("b2b_div_final", 32'(divOut), 32'h004);
        checkOutput("b2b_stat", 32'(stat), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
